// File: rtl/bus_arbiter_pkg.sv
// Shared types for the bus arbiter: FSM states, slot phases, defaults.
// Optional stats output is enabled with BUS_ARBITER_STATS_EN.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BA_WAIT = 2'd1,
        STEAL   = 2'd2
    } state_e;

    localparam logic PH_VIC = 1'b0;
    localparam logic PH_CPU = 1'b1;

    localparam int BA_DELAY_DEF = 3;
    localparam int STAT_W       = 16;

endpackage

// File: rtl/bus_arbiter_stats.sv
// Saturating counter of clks spent in cycle-steal bursts.
// Instantiated only when BUS_ARBITER_STATS_EN is defined.
module bus_arbiter_stats
    import bus_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              steal_i,
    output logic [STAT_W-1:0] cnt_o
);

    logic [STAT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (steal_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_arbiter.sv
// CPU/video shared-bus arbiter with BA hold-off and cycle-steal bursts.
// Define BUS_ARBITER_STATS_EN to add the steal_cnt statistics output.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int BA_DELAY = BA_DELAY_DEF,
    parameter int LEN_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      cpu_ab,
    input  logic [7:0]       cpu_do,
    input  logic             cpu_we,
    output logic [7:0]       cpu_di,
    output logic             cpu_rdy,
    input  logic             vic_req,
    input  logic [LEN_W-1:0] vic_len,
    input  logic [15:0]      vic_ab,
    output logic [7:0]       vic_di,
    output logic             aec,
`ifdef BUS_ARBITER_STATS_EN
    output logic [15:0]      steal_cnt,
`endif
    output logic [15:0]      mem_ab,
    output logic [7:0]       mem_do,
    output logic             mem_we,
    input  logic [7:0]       mem_di
);

    localparam int WAIT_W = (BA_DELAY < 2) ? 1 : $clog2(BA_DELAY + 1);

    state_e            state_q, state_d;
    logic              phase_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [LEN_W-1:0]  burst_q, burst_d;
    logic              cpu_rdy_q, aec_q;
    logic [7:0]        cpu_di_q, vic_di_q;
    logic              accept;
    logic              cpu_slot;
    logic              cpu_cap, vic_cap;

    assign accept = vic_req && (vic_len != '0);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BA_WAIT;
                    wait_d  = WAIT_W'(BA_DELAY);
                    burst_d = vic_len;
                end
            end
            BA_WAIT: begin
                // Countdown runs in CPU slots so STEAL always opens on a VIC slot
                if (phase_q == PH_CPU) begin
                    if (wait_q <= WAIT_W'(1)) begin
                        state_d = STEAL;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end
            end
            STEAL: begin
                if (burst_q <= LEN_W'(1)) begin
                    if (accept) begin
                        burst_d = vic_len;
                    end else begin
                        state_d = IDLE;
                        burst_d = '0;
                    end
                end else begin
                    burst_d = burst_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_slot = (state_q != STEAL) && (phase_q == PH_CPU);

    always_comb begin
        mem_ab = vic_ab;
        mem_do = cpu_do;
        mem_we = 1'b0;
        if (cpu_slot) begin
            mem_ab = cpu_ab;
            mem_we = cpu_we & ~reset;
        end
    end

    assign cpu_cap = (phase_q == PH_CPU) && aec_q && !mem_we;
    assign vic_cap = (phase_q == PH_VIC) || (state_q == STEAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= PH_VIC;
            wait_q    <= '0;
            burst_q   <= '0;
            cpu_rdy_q <= 1'b1;
            aec_q     <= 1'b1;
            cpu_di_q  <= '0;
            vic_di_q  <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= ~phase_q;
            wait_q    <= wait_d;
            burst_q   <= burst_d;
            cpu_rdy_q <= (state_d == IDLE);
            aec_q     <= (state_d != STEAL);
            if (cpu_cap) begin
                cpu_di_q <= mem_di;
            end
            if (vic_cap) begin
                vic_di_q <= mem_di;
            end
        end
    end

    assign cpu_rdy = cpu_rdy_q;
    assign aec     = aec_q;
    assign cpu_di  = cpu_di_q;
    assign vic_di  = vic_di_q;

`ifdef BUS_ARBITER_STATS_EN
    bus_arbiter_stats u_stats (
        .clk     (clk),
        .reset   (reset),
        .steal_i (state_q == STEAL),
        .cnt_o   (steal_cnt)
    );
`endif

endmodule
